// File: rtl/soc_top.sv
// Single-cycle RV32I SoC: core, register file, unified instruction/data ROM and data RAM.
// Memories read combinationally and write on the rising edge with per-byte enables.

module soc_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

module soc_rom #(
  parameter int WORDS = 4096,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] iidx,
  output logic [31:0]   irdata,
  input  logic [AW-1:0] didx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   drdata
);
  logic [31:0] _rom [0:WORDS-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (be[b]) _rom[didx][8*b +: 8] <= wdata[8*b +: 8];
  end

  assign irdata = _rom[iidx];
  assign drdata = _rom[didx];
endmodule

module soc_ram #(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end

  assign rdata = mem[idx];
endmodule

module soc_core (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

  logic [31:0] pc_q, pc_d, instr, rs1_v, rs2_v, rf_wd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        rf_we, take;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic alt);
    case (op)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign imem_addr = pc_q;
  assign instr     = imem_rdata;
  assign opcode    = instr[6:0];
  assign f3        = instr[14:12];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'd0};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  soc_regs u_regs (
    .clk(clk), .rst(rst), .we(rf_we), .waddr(instr[11:7]), .wdata(rf_wd),
    .raddr1(instr[19:15]), .raddr2(instr[24:20]), .rdata1(rs1_v), .rdata2(rs2_v)
  );

  // Address is a separate path so the load mux below does not loop back onto it.
  assign dmem_addr = rs1_v + ((opcode == OP_ST) ? imm_s : imm_i);
  assign ld_b      = dmem_rdata[8*dmem_addr[1:0] +: 8];
  assign ld_h      = dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    dmem_wdata = rs2_v;
    dmem_be    = '0;
    if (rst && opcode == OP_ST) begin
      case (f3)
        3'd0: begin dmem_be = 4'b0001 << dmem_addr[1:0]; dmem_wdata = {4{rs2_v[7:0]}}; end
        3'd1: begin dmem_be = dmem_addr[1] ? 4'b1100 : 4'b0011; dmem_wdata = {2{rs2_v[15:0]}}; end
        3'd2: dmem_be = 4'b1111;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (f3)
      3'd0:    take = rs1_v == rs2_v;
      3'd1:    take = rs1_v != rs2_v;
      3'd4:    take = $signed(rs1_v) <  $signed(rs2_v);
      3'd5:    take = $signed(rs1_v) >= $signed(rs2_v);
      3'd6:    take = rs1_v <  rs2_v;
      3'd7:    take = rs1_v >= rs2_v;
      default: take = 1'b0;
    endcase
  end

  // Anything not matched below (fence, system, csr, unknown) falls through as a NOP.
  always_comb begin
    pc_d  = pc_q + 32'd4;
    rf_we = 1'b0;
    rf_wd = '0;
    case (opcode)
      OP_LUI:   begin rf_we = 1'b1; rf_wd = imm_u; end
      OP_AUIPC: begin rf_we = 1'b1; rf_wd = pc_q + imm_u; end
      OP_JAL:   begin rf_we = 1'b1; rf_wd = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      OP_JALR:  begin rf_we = 1'b1; rf_wd = pc_q + 32'd4; pc_d = (rs1_v + imm_i) & ~32'd1; end
      OP_BR:    if (take) pc_d = pc_q + imm_b;
      OP_LD: begin
        rf_we = 1'b1;
        case (f3)
          3'd0:    rf_wd = {{24{ld_b[7]}}, ld_b};
          3'd1:    rf_wd = {{16{ld_h[15]}}, ld_h};
          3'd2:    rf_wd = dmem_rdata;
          3'd4:    rf_wd = {24'd0, ld_b};
          3'd5:    rf_wd = {16'd0, ld_h};
          default: rf_we = 1'b0;
        endcase
      end
      OP_IMM:   begin rf_we = 1'b1; rf_wd = alu(rs1_v, imm_i, f3, f3 == 3'd5 && instr[30]); end
      OP_REG:   begin rf_we = 1'b1; rf_wd = alu(rs1_v, rs2_v, f3, instr[30]); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end
endmodule

module soc_top #(
  parameter int ROM_WORDS = 4096,
  parameter int RAM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  localparam int ROM_AW = $clog2(ROM_WORDS);
  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic [31:0] iaddr, irdata, daddr, dwdata, drdata, rom_rd, ram_rd;
  logic [3:0]  dbe;
  logic        rom_sel, ram_sel;

  soc_core u_core (
    .clk(clk), .rst(rst), .imem_addr(iaddr), .imem_rdata(irdata),
    .dmem_addr(daddr), .dmem_wdata(dwdata), .dmem_be(dbe), .dmem_rdata(drdata)
  );

  // Unsigned subtract makes addresses below the RAM base compare as huge.
  assign rom_sel = daddr < 32'(4 * ROM_WORDS);
  assign ram_sel = (daddr - 32'h1000_0000) < 32'(4 * RAM_WORDS);
  assign drdata  = rom_sel ? rom_rd : ram_sel ? ram_rd : '0;

  soc_rom #(.WORDS(ROM_WORDS)) u_rom (
    .clk(clk), .iidx(iaddr[ROM_AW+1:2]), .irdata(irdata), .didx(daddr[ROM_AW+1:2]),
    .be(rom_sel ? dbe : 4'd0), .wdata(dwdata), .drdata(rom_rd)
  );

  soc_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clk(clk), .idx(daddr[RAM_AW+1:2]), .be(ram_sel ? dbe : 4'd0), .wdata(dwdata), .rdata(ram_rd)
  );
endmodule

// File: tb/tb_soc_top.sv
// Directed bench for soc_top: single-instruction vector table plus short hand-built programs.
module tb_soc_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  soc_top dut (.clk(clk), .rst(rst));

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_rd;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) dut.u_rom._rom[i] = NOP;
    dut.u_ram.mem[0] = '0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs.push_back('{"add",    enc_r(7'h00, 2, 1, 0, 3), 32'd5, 32'd7, 32'd12, 32'd4});
    vecs.push_back('{"sub",    enc_r(7'h20, 2, 1, 0, 3), 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd4});
    vecs.push_back('{"sll",    enc_r(7'h00, 2, 1, 1, 3), 32'd1, 32'h21, 32'd2, 32'd4});
    vecs.push_back('{"slt",    enc_r(7'h00, 2, 1, 2, 3), 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd4});
    vecs.push_back('{"sltu",   enc_r(7'h00, 2, 1, 3, 3), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd4});
    vecs.push_back('{"xor",    enc_r(7'h00, 2, 1, 4, 3), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 32'd4});
    vecs.push_back('{"srl",    enc_r(7'h00, 2, 1, 5, 3), 32'h8000_0000, 32'd4, 32'h0800_0000, 32'd4});
    vecs.push_back('{"sra",    enc_r(7'h20, 2, 1, 5, 3), 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd4});
    vecs.push_back('{"or",     enc_r(7'h00, 2, 1, 6, 3), 32'hF0, 32'h0F, 32'hFF, 32'd4});
    vecs.push_back('{"and",    enc_r(7'h00, 2, 1, 7, 3), 32'hF0, 32'h3C, 32'h30, 32'd4});
    vecs.push_back('{"addi",   enc_i(12'hFFF, 1, 0, 3, 7'h13), 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd4});
    vecs.push_back('{"srai",   enc_i(12'h41F, 1, 5, 3, 7'h13), 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd4});
    vecs.push_back('{"sltiu",  enc_i(12'hFFF, 1, 3, 3, 7'h13), 32'd5, 32'd0, 32'd1, 32'd4});
    vecs.push_back('{"lui",    enc_u(20'h12345, 3, 7'h37), 32'd0, 32'd0, 32'h1234_5000, 32'd4});
    vecs.push_back('{"auipc",  enc_u(20'h00001, 3, 7'h17), 32'd0, 32'd0, 32'h0000_1000, 32'd4});
    vecs.push_back('{"bltu",   enc_b(13'd8, 2, 1, 6), 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd8});
    vecs.push_back('{"blt",    enc_b(13'd8, 2, 1, 4), 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd4});
    vecs.push_back('{"beq",    enc_b(13'd8, 2, 1, 0), 32'd3, 32'd3, 32'd0, 32'd8});
    vecs.push_back('{"jalr",   enc_i(12'd5, 1, 0, 3, 7'h67), 32'h100, 32'd0, 32'd4, 32'h104});
    vecs.push_back('{"ecall",  32'h0000_0073, 32'd1, 32'd2, 32'd0, 32'd4});
    vecs.push_back('{"csrrw",  enc_i(12'h300, 1, 1, 3, 7'h73), 32'd9, 32'd2, 32'd0, 32'd4});

    // Reset with garbage in the register file.
    for (int i = 0; i < 64; i++) dut.u_rom._rom[i] = NOP;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i < 32; i++) dut.u_core.u_regs.regs[i] = 32'hA5A5_0000 | i;
    steps(2);
    rst = 1'b0;
    #40;
    chk("reset_pc", dut.u_core.pc_q, 32'd0);
    for (int i = 1; i < 32; i++) chk($sformatf("reset_x%0d", i), dut.u_core.u_regs.regs[i], 32'd0);

    // A store sitting at PC 0 must not write while reset is held; it retires on the first edge after.
    hold_reset();
    dut.u_rom._rom[0] = enc_s(12'd8, 0, 0, 2);
    dut.u_rom._rom[2] = 32'hDEAD_BEEF;
    steps(3);
    chk("rst_no_store", dut.u_rom._rom[2], 32'hDEAD_BEEF);
    release_rst();
    steps(1);
    chk("first_retire_store", dut.u_rom._rom[2], 32'd0);
    chk("first_retire_pc", dut.u_core.pc_q, 32'd4);

    foreach (vecs[k]) begin
      hold_reset();
      dut.u_rom._rom[0] = vecs[k].instr;
      release_rst();
      dut.u_core.u_regs.regs[1] = vecs[k].a;
      dut.u_core.u_regs.regs[2] = vecs[k].b;
      steps(1);
      chk({vecs[k].name, "_rd"}, dut.u_core.u_regs.regs[3], vecs[k].exp_rd);
      chk({vecs[k].name, "_pc"}, dut.u_core.pc_q, vecs[k].exp_pc);
    end

    // Two-instruction program.
    hold_reset();
    dut.u_rom._rom[0] = enc_i(12'd1, 0, 0, 26, 7'h13);
    dut.u_rom._rom[1] = enc_i(12'd1, 0, 0, 27, 7'h13);
    release_rst();
    steps(2);
    chk("prog_x26", dut.u_core.u_regs.regs[26], 32'd1);
    chk("prog_x27", dut.u_core.u_regs.regs[27], 32'd1);
    chk("prog_x3", dut.u_core.u_regs.regs[3], 32'd0);

    // Byte/half/word loads and stores, misaligned word, unmapped region.
    hold_reset();
    dut.u_rom._rom[0]  = enc_u(20'h10000, 5, 7'h37);
    dut.u_rom._rom[1]  = enc_i(12'hF80, 0, 0, 6, 7'h13);
    dut.u_rom._rom[2]  = enc_s(12'd1, 6, 5, 0);
    dut.u_rom._rom[3]  = enc_i(12'd1, 5, 0, 7, 7'h03);
    dut.u_rom._rom[4]  = enc_i(12'd1, 5, 4, 8, 7'h03);
    dut.u_rom._rom[5]  = enc_i(12'd0, 5, 2, 9, 7'h03);
    dut.u_rom._rom[6]  = enc_s(12'd2, 6, 5, 1);
    dut.u_rom._rom[7]  = enc_i(12'd2, 5, 1, 12, 7'h03);
    dut.u_rom._rom[8]  = enc_i(12'd2, 5, 5, 13, 7'h03);
    dut.u_rom._rom[9]  = enc_i(12'd3, 5, 2, 14, 7'h03);
    dut.u_rom._rom[10] = enc_u(20'h20000, 11, 7'h37);
    dut.u_rom._rom[11] = enc_s(12'd0, 6, 11, 2);
    dut.u_rom._rom[12] = enc_i(12'd0, 11, 2, 10, 7'h03);
    release_rst();
    dut.u_core.u_regs.regs[10] = 32'h1234;
    steps(13);
    chk("lb", dut.u_core.u_regs.regs[7], 32'hFFFF_FF80);
    chk("lbu", dut.u_core.u_regs.regs[8], 32'h0000_0080);
    chk("lw_after_sb", dut.u_core.u_regs.regs[9], 32'h0000_8000);
    chk("lh", dut.u_core.u_regs.regs[12], 32'hFFFF_FF80);
    chk("lhu", dut.u_core.u_regs.regs[13], 32'h0000_FF80);
    chk("lw_misaligned", dut.u_core.u_regs.regs[14], 32'hFF80_8000);
    chk("lw_unmapped", dut.u_core.u_regs.regs[10], 32'd0);
    chk("ram_word0", dut.u_ram.mem[0], 32'hFF80_8000);

    // x0 write discarded, jal link and target, skipped instruction.
    hold_reset();
    dut.u_rom._rom[3] = enc_i(12'd5, 0, 0, 0, 7'h13);
    dut.u_rom._rom[4] = enc_j(21'd8, 1);
    dut.u_rom._rom[5] = enc_i(12'd9, 0, 0, 4, 7'h13);
    release_rst();
    steps(5);
    chk("x0_zero", dut.u_core.u_regs.regs[0], 32'd0);
    chk("jal_link", dut.u_core.u_regs.regs[1], 32'h14);
    chk("jal_pc", dut.u_core.pc_q, 32'h18);
    steps(1);
    chk("jal_skip_x4", dut.u_core.u_regs.regs[4], 32'd0);

    // Self-modifying code: overwrite a later instruction with NOP, then ecall/csrrw as NOPs.
    hold_reset();
    dut.u_rom._rom[0] = enc_i(12'h013, 0, 0, 6, 7'h13);
    dut.u_rom._rom[1] = enc_s(12'd12, 6, 0, 2);
    dut.u_rom._rom[3] = enc_i(12'd7, 0, 0, 7, 7'h13);
    dut.u_rom._rom[4] = 32'h0000_0073;
    dut.u_rom._rom[5] = enc_i(12'h300, 6, 1, 8, 7'h73);
    release_rst();
    steps(6);
    chk("smc_rom3", dut.u_rom._rom[3], NOP);
    chk("smc_x7", dut.u_core.u_regs.regs[7], 32'd0);
    chk("sys_x8", dut.u_core.u_regs.regs[8], 32'd0);
    chk("sys_pc", dut.u_core.pc_q, 32'h18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/soc_top.md
SOC_TOP -- requirements
Module: soc_top

Interface
REQ-001 Parameter ROM_WORDS, default 4096, sets the depth of the unified instruction/data memory in 32-bit words.
REQ-002 Parameter RAM_WORDS, default 1024, sets the depth of the data RAM in 32-bit words.
REQ-003 clk  input  1  system clock, 50 MHz nominal, all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock, asynchronous assert, active-low (rst=0 resets the SoC).
REQ-005 The SoC SHALL have no other ports; its state is observed hierarchically.
REQ-006 The hierarchy SHALL expose u_core.u_regs.regs[0:31] (32-bit each) and u_rom._rom[0:ROM_WORDS-1] (32-bit words, $readmemh-loadable, word 0 = address 0x0000_0000).

Function
REQ-007 u_core SHALL be a single-cycle, in-order RV32I core: one instruction fetched, executed and retired per clk cycle.
REQ-008 Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU instructions including shifts (shamt = low 5 bits).
REQ-009 FENCE, FENCE.I, ECALL, EBREAK, CSR instructions and any unrecognised opcode SHALL execute as NOP (PC+4, no register or memory write).
REQ-010 Arithmetic SHALL be 32-bit modulo 2^32; SLT/SLTI/BLT/BGE signed, SLTU/SLTIU/BLTU/BGEU unsigned; SRA/SRAI arithmetic.
REQ-011 regs[0] SHALL read 0 always; writes to x0 SHALL be discarded; register writes occur at the rising clk edge ending the instruction.
REQ-012 Register reads SHALL be combinational from regs.
REQ-013 JAL/JALR SHALL write PC+4 to rd; JALR target = (rs1+imm) with bit 0 cleared.
REQ-014 Taken branch/jump SHALL load the target into PC on the same edge; no delay slot, no flush penalty.
REQ-015 Memory map: 0x0000_0000-(4*ROM_WORDS-1) -> u_rom; 0x1000_0000-0x1000_0000+(4*RAM_WORDS-1) -> RAM; other addresses: loads return 0, stores ignored.
REQ-016 u_rom SHALL serve instruction fetch (combinational read, index PC[..:2]) and data load/store in the same cycle; stores to u_rom are permitted and visible to later fetches.
REQ-017 Memory reads SHALL be combinational; memory writes SHALL occur at the rising clk edge with per-byte enables.
REQ-018 SB writes the byte lane addr[1:0]; SH writes lanes addr[1]*2..+1; SW writes all 4 lanes.
REQ-019 LB/LH SHALL sign-extend, LBU/LHU zero-extend, selecting the lane by addr[1:0]/addr[1].
REQ-020 Misaligned halfword/word accesses SHALL use the word at addr[31:2] with addr low bits ignored (no trap).
REQ-021 Index bits beyond memory depth SHALL be ignored (address wraps within each region).

Reset
REQ-022 While rst=0: PC=0x0000_0000, regs[1..31]=0, no memory write; memory contents preserved.
REQ-023 Reset assertion mid-instruction SHALL abort it with no register or memory write.
REQ-024 First instruction (address 0) SHALL retire at the first rising clk edge after rst rises.

Verification
REQ-025 rst=0 for 40 ns with garbage in regs -> PC=0, regs[1..31]=0; after release, fetch starts at 0x0.
REQ-026 ROM: addi x26,x0,1; addi x27,x0,1 -> after 2 edges x26=1, x27=1, x3=0.
REQ-027 lui x5,0x10000; addi x6,x0,-128; sb x6,1(x5); lb x7,1(x5); lbu x8,1(x5); lw x9,0(x5) -> x7=0xFFFFFF80, x8=0x80, x9=0x00008000.
REQ-028 addi x0,x0,5; jal x1,+8 at 0x10 -> x0=0, x1=0x14, next PC 0x18; bltu with x1=1, x2=0xFFFFFFFF taken, blt not taken.
REQ-029 sw 0x00000013 (NOP) over a later ROM word, then execute it -> stored word is executed; ecall/csrrw -> NOP, PC+4.
REQ-030 Run rv32ui test image from $readmemh -> x26 becomes 1 with x27=1 before 500 us timeout.
